awgn_scale_out: RTL

Downstream neighbour of the square-root stage in the AWGN generator. Takes the Box-Muller magnitude f (the square-root output, unsigned) together with the aligned sin/cos pair (g0, g1), and forms x0 = f·g0 and x1 = f·g1 with rounding and saturation. The pair is buffered in a small FIFO and serialized onto a single valid/ready sample stream, x0 first and then x1.

---
 rtl/awgn_scale_out_if.sv | 43 ++++
 rtl/awgn_scale_out.sv | 137 +++++++++++++
 2 files changed

// File: rtl/awgn_scale_out_if.sv
// awgn_scale_out_if -- stream bundle for awgn_scale_out.
//
// Valid/ready rule for both streams: a word moves on a rising clock edge
// where valid && ready. The producer holds valid and data steady until that
// edge, and valid never depends combinationally on ready.
//
// Signals:
//   in_valid / in_ready   input handshake (f_in, g0_in, g1_in aligned)
//   f_in                  magnitude, unsigned UQ4.13
//   g0_in / g1_in         cos / sin terms, signed Q1.15
//   out_valid / out_ready output sample handshake
//   out_data              Gaussian sample, signed Q3.12
//   sel_dbg               serializer state (0 = x0 next, 1 = x1 next)
//   count_dbg             FIFO occupancy in pairs
//
// Modports: slave = the block, master = the environment driving it.
// DEPTH must match the DEPTH of the awgn_scale_out instance it connects to.
interface awgn_scale_out_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [16:0]   f_in;
    logic [15:0]   g0_in;
    logic [15:0]   g1_in;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          sel_dbg;
    logic [CW-1:0] count_dbg;

    modport slave (
        input  in_valid, f_in, g0_in, g1_in, out_ready,
        output in_ready, out_valid, out_data, sel_dbg, count_dbg
    );

    modport master (
        output in_valid, f_in, g0_in, g1_in, out_ready,
        input  in_ready, out_valid, out_data, sel_dbg, count_dbg
    );
endinterface

// File: rtl/awgn_scale_out.sv
// awgn_scale_out -- Box-Muller output scaling and serialization.
//
// Forms x0 = f*g0 and x1 = f*g1 (UQ4.13 x Q1.15 -> Q3.12) with a >>>16
// shift and saturation, buffers the pair in a DEPTH-entry FIFO and emits
// x0 then x1 on a single valid/ready stream.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  awgn_scale_out_if.slave (input stream, output stream, debug)
//
// Build option:
//   AWGN_ROUND_EN  defined: add 2^15 before the shift (round-half-up);
//                  undefined: plain arithmetic shift (floor).
module awgn_scale_out #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    awgn_scale_out_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {SEL_X0 = 1'b0, SEL_X1 = 1'b1} sel_t;

    // Stage 1: raw products
    logic                 s1_valid;
    logic signed [32:0]   p0, p1;
    logic signed [17:0]   f_s;
    logic                 accept;

    // FIFO
    logic [31:0]          mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop;

    // Serializer
    sel_t                 sel_q, sel_d;
    logic                 xfer;

    logic [15:0]          x0_s2, x1_s2;

    // Shift by 16 with optional rounding, then clamp to 16-bit signed.
    // 34-bit working width keeps the rounding add free of overflow.
    function automatic logic [15:0] scale_sat(input logic signed [32:0] p);
        logic signed [33:0] sum;
        logic signed [33:0] r;
        sum = 34'(p);
`ifdef AWGN_ROUND_EN
        sum = sum + 34'sd32768;
`endif
        r = sum >>> 16;
        if (r > 34'sd32767)
            scale_sat = 16'h7FFF;
        else if (r < -34'sd32768)
            scale_sat = 16'h8000;
        else
            scale_sat = r[15:0];
    endfunction

    // Credit counts the pair still in stage 1; a pop this cycle is not
    // credited, keeping out_ready off the in_ready path.
    assign bus.in_ready = ({1'b0, count} + (CW+1)'(s1_valid)) < DEPTH_W;
    assign accept       = bus.in_valid && bus.in_ready;
    assign f_s          = {1'b0, bus.f_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s1_valid <= 1'b0;
        else      s1_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            p0 <= 33'(f_s) * 33'($signed(bus.g0_in));
            p1 <= 33'(f_s) * 33'($signed(bus.g1_in));
        end
    end

    // Stage 2: combinational scaling into the FIFO write port
    assign x0_s2 = scale_sat(p0);
    assign x1_s2 = scale_sat(p1);
    assign push  = s1_valid;

    // Storage is not reset; count == 0 masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {x0_s2, x1_s2};
    end

    assign bus.out_valid = (count != '0);
    assign xfer          = bus.out_valid && bus.out_ready;

    always_comb begin
        bus.out_data = 16'h0000;
        if (count != '0)
            bus.out_data = (sel_q == SEL_X1) ? mem[rd_ptr][15:0] : mem[rd_ptr][31:16];
    end

    // Serializer next-state: x0 transfer arms x1, x1 transfer pops the pair.
    always_comb begin
        sel_d = sel_q;
        pop   = 1'b0;
        if (xfer) begin
            case (sel_q)
                SEL_X0: sel_d = SEL_X1;
                SEL_X1: begin
                    sel_d = SEL_X0;
                    pop   = 1'b1;
                end
                default: sel_d = SEL_X0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q  <= SEL_X0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            sel_q <= sel_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.sel_dbg   = sel_q;
    assign bus.count_dbg = count;
endmodule
